// File: rtl/lin_sys_ctrl_pkg.sv
// Shared types and constants for the linear-system solver controller.
package lin_sys_ctrl_pkg;

    localparam int DW_DEF   = 16;
    localparam int FRAC_DEF = 4;

    function automatic int fp_one(input int frac);
        return 1 << frac;
    endfunction

    localparam int FP_ONE = fp_one(FRAC_DEF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_OVF     = 3'd1;
    localparam logic [2:0] ERR_DBZ     = 3'd2;
    localparam logic [2:0] ERR_FSM     = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    // Overflow outranks divide-by-zero, which outranks an internal solver fault.
    function automatic logic [2:0] solver_err_code(input logic ovf, input logic dbz,
                                                   input logic fsm);
        if (ovf) return ERR_OVF;
        if (dbz) return ERR_DBZ;
        if (fsm) return ERR_FSM;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/lin_sys_ctrl_if.sv
// Coefficient write bus plus solver launch/status handshake.
interface lin_sys_ctrl_if #(
    parameter int DW = 16,
    parameter int N  = 3
);
    logic              wr_valid;
    logic              wr_ready;
    logic [4:0]        wr_addr;
    logic [DW-1:0]     wr_data;
    logic              start;
    logic              solver_en;
    logic [N*N*DW-1:0] a_flat;
    logic [N*DW-1:0]   c_flat;
    logic [N*DW-1:0]   x_flat;
    logic              solver_done;
    logic              err_ovf;
    logic              err_dbz;
    logic              err_fsm;

    modport master (
        output wr_valid, wr_addr, wr_data, start,
        output x_flat, solver_done, err_ovf, err_dbz, err_fsm,
        input  wr_ready, solver_en, a_flat, c_flat
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, start,
        input  x_flat, solver_done, err_ovf, err_dbz, err_fsm,
        output wr_ready, solver_en, a_flat, c_flat
    );
endinterface

// File: rtl/lin_sys_ctrl_readout_mux.sv
// Read-out word select (bank/result words or auto-scrolled results) with registered output.
module lin_sys_readout_mux #(
    parameter int            DW         = 16,
    parameter int            N          = 3,
    parameter int            SCROLL_DIV = 50_000_000,
    parameter logic [DW-1:0] SENTINEL   = 16'h0FF0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*N*DW-1:0] a_flat,
    input  logic [N*DW-1:0]   c_flat,
    input  logic [N*DW-1:0]   x_flat,
    input  logic [4:0]        rd_sel,
    input  logic              scroll_en,
    output logic [DW-1:0]     rd_data
);
    localparam int             SW       = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int             IW       = $clog2(N);
    localparam logic [SW-1:0]  DIV_LOAD = SW'(SCROLL_DIV - 1);

    logic [SW-1:0] div_q;
    logic [IW-1:0] idx_q;
    logic [DW-1:0] word;

    always_comb begin
        word = SENTINEL;
        if (scroll_en) begin
            for (int i = 0; i < N; i++)
                if (idx_q == IW'(i)) word = x_flat[i*DW +: DW];
        end else begin
            for (int i = 0; i < N; i++)
                if (rd_sel == 5'(i)) word = x_flat[i*DW +: DW];
            for (int i = 0; i < N*N; i++)
                if (rd_sel == 5'(N + i)) word = a_flat[i*DW +: DW];
            for (int i = 0; i < N; i++)
                if (rd_sel == 5'(N + N*N + i)) word = c_flat[i*DW +: DW];
        end
    end

    // Holding the divider/index in reset while scroll is off makes every enable start at X[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            idx_q   <= '0;
            div_q   <= DIV_LOAD;
        end else begin
            rd_data <= word;
            if (!scroll_en) begin
                idx_q <= '0;
                div_q <= DIV_LOAD;
            end else if (div_q == '0) begin
                div_q <= DIV_LOAD;
                idx_q <= (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                div_q <= div_q - 1'b1;
            end
        end
    end
endmodule

// File: rtl/lin_sys_ctrl.sv
// Solver controller: coefficient bank, launch/watchdog FSM, result latch and read-out.
// state   | meaning
// IDLE    | after reset, bank writable, waiting for start
// RUN     | solver enabled, watchdog counting, bank locked
// DONE    | solver finished cleanly, results latched
// ERR     | solver error or watchdog expiry, err_code holds cause
module lin_sys_ctrl
    import lin_sys_ctrl_pkg::*;
#(
    parameter int            DW         = DW_DEF,
    parameter int            FRAC       = FRAC_DEF,
    parameter int            N          = 3,
    parameter int            TIMEOUT    = 4096,
    parameter int            SCROLL_DIV = 50_000_000,
    parameter logic [DW-1:0] SENTINEL   = 16'h0FF0
) (
    input  logic          clk,
    input  logic          rst,
    lin_sys_ctrl_if.slave bus,
    output logic          busy,
    output logic          done,
    output logic [2:0]    err_code,
    output logic          addr_err,
    input  logic [4:0]    rd_sel,
    input  logic          scroll_en,
    output logic [DW-1:0] rd_data
);
    localparam int            NA      = N * N;
    localparam int            NB      = NA + N;
    localparam int            TW      = $clog2(TIMEOUT);
    localparam logic [TW-1:0] WD_LOAD = TW'(TIMEOUT - 1);

    function automatic logic [NA*DW-1:0] identity();
        logic [NA*DW-1:0] v;
        v = '0;
        for (int r = 0; r < N; r++)
            v[(r*N + r)*DW +: DW] = DW'(fp_one(FRAC));
        return v;
    endfunction

    state_t           state_q, state_nxt;
    logic [2:0]       err_q, err_nxt;
    logic [TW-1:0]    wd_q;
    logic             ld_wd, ld_res, wr_fire, addr_err_q;
    logic [NA*DW-1:0] a_q;
    logic [N*DW-1:0]  c_q, x_q;

    assign wr_fire = bus.wr_valid && bus.wr_ready;

    // Watchdog is a down-counter; a completion on its terminal cycle still wins.
    always_comb begin
        state_nxt = state_q;
        err_nxt   = err_q;
        ld_wd     = 1'b0;
        ld_res    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (bus.solver_done) begin
                    err_nxt   = solver_err_code(bus.err_ovf, bus.err_dbz, bus.err_fsm);
                    ld_res    = (err_nxt == ERR_NONE);
                    state_nxt = ld_res ? ST_DONE : ST_ERR;
                end else if (wd_q == '0) begin
                    err_nxt   = ERR_TIMEOUT;
                    state_nxt = ST_ERR;
                end
            end
            default: begin
                if (bus.start) begin
                    state_nxt = ST_RUN;
                    err_nxt   = ERR_NONE;
                    ld_wd     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            err_q      <= ERR_NONE;
            wd_q       <= WD_LOAD;
            addr_err_q <= 1'b0;
            a_q        <= identity();
            c_q        <= '0;
            x_q        <= '0;
        end else begin
            state_q <= state_nxt;
            err_q   <= err_nxt;
            if (ld_wd)
                wd_q <= WD_LOAD;
            else if (state_q == ST_RUN)
                wd_q <= wd_q - 1'b1;
            if (ld_res)
                x_q <= bus.x_flat;
            if (wr_fire) begin
                for (int i = 0; i < NA; i++)
                    if (bus.wr_addr == 5'(i)) a_q[i*DW +: DW] <= bus.wr_data;
                for (int i = 0; i < N; i++)
                    if (bus.wr_addr == 5'(NA + i)) c_q[i*DW +: DW] <= bus.wr_data;
                if (bus.wr_addr >= 5'(NB))
                    addr_err_q <= 1'b1;
            end
        end
    end

    assign busy          = (state_q == ST_RUN);
    assign done          = (state_q == ST_DONE);
    assign bus.solver_en = busy;
    assign bus.wr_ready  = !busy;
    assign bus.a_flat    = a_q;
    assign bus.c_flat    = c_q;
    assign err_code      = err_q;
    assign addr_err      = addr_err_q;

    lin_sys_readout_mux #(
        .DW         (DW),
        .N          (N),
        .SCROLL_DIV (SCROLL_DIV),
        .SENTINEL   (SENTINEL)
    ) u_readout (
        .clk       (clk),
        .rst       (rst),
        .a_flat    (a_q),
        .c_flat    (c_q),
        .x_flat    (x_q),
        .rd_sel    (rd_sel),
        .scroll_en (scroll_en),
        .rd_data   (rd_data)
    );
endmodule

// File: tb/tb_lin_sys_ctrl.sv
// Randomized bench for lin_sys_ctrl against a transaction-level model of bank, solve and read-out.
module tb_lin_sys_ctrl;
    import lin_sys_ctrl_pkg::*;

    localparam int DW = 16, FRAC = 4, N = 3, TIMEOUT = 16, SCROLL_DIV = 4;
    localparam int NA = N * N, NB = NA + N;
    localparam logic [15:0] SENT = 16'h0FF0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy, done, addr_err, scroll_en;
    logic [2:0]  err_code;
    logic [4:0]  rd_sel;
    logic [15:0] rd_data;

    lin_sys_ctrl_if #(.DW(DW), .N(N)) bus ();

    lin_sys_ctrl #(
        .DW(DW), .FRAC(FRAC), .N(N), .TIMEOUT(TIMEOUT),
        .SCROLL_DIV(SCROLL_DIV), .SENTINEL(SENT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .done(done),
        .err_code(err_code), .addr_err(addr_err), .rd_sel(rd_sel),
        .scroll_en(scroll_en), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] a_m [NA];
    logic [15:0] c_m [N];
    logic [47:0] x_m;
    logic [2:0]  err_m;
    logic        done_m;
    logic        addr_err_m;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] pack_a();
        logic [255:0] v = '0;
        for (int i = 0; i < NA; i++) v[i*16 +: 16] = a_m[i];
        return v;
    endfunction

    function automatic logic [255:0] pack_c();
        logic [255:0] v = '0;
        for (int i = 0; i < N; i++) v[i*16 +: 16] = c_m[i];
        return v;
    endfunction

    function automatic logic [15:0] exp_read(input int sel);
        if (sel < N)      return x_m[sel*16 +: 16];
        if (sel < N + NA) return a_m[sel - N];
        if (sel < N + NB) return c_m[sel - N - NA];
        return SENT;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                a_m[r*N + c] = (r == c) ? 16'(FP_ONE) : 16'h0000;
        for (int i = 0; i < N; i++) c_m[i] = 16'h0000;
        x_m = '0; err_m = 3'd0; done_m = 1'b0; addr_err_m = 1'b0;
    endtask

    task automatic model_write(input int addr, input logic [15:0] data);
        if (addr < NA)      a_m[addr] = data;
        else if (addr < NB) c_m[addr - NA] = data;
        else                addr_err_m = 1'b1;
    endtask

    task automatic check_bank(input string tag);
        check_val({tag, "_a_flat"}, bus.a_flat, pack_a());
        check_val({tag, "_c_flat"}, bus.c_flat, pack_c());
        check_val({tag, "_addr_err"}, addr_err, addr_err_m);
    endtask

    task automatic do_write(input int addr, input logic [15:0] data);
        bus.wr_valid = 1'b1; bus.wr_addr = 5'(addr); bus.wr_data = data;
        check_val("wr_ready_idle", bus.wr_ready, 1'b1);
        tick();
        bus.wr_valid = 1'b0;
        model_write(addr, data);
        check_bank($sformatf("wr%0d", addr));
    endtask

    task automatic read_check(input int sel);
        rd_sel = 5'(sel);
        tick();
        tick();
        check_val($sformatf("rd_sel%0d", sel), rd_data, exp_read(sel));
    endtask

    // Solver responds with done on RUN cycle 'lat'; lat >= TIMEOUT means it never answers.
    task automatic run_solve(input int lat, input logic ovf, input logic dbz, input logic fsm,
                             input logic [47:0] xv, input logic co_write);
        int cycles, exp_cycles, ca;
        logic [2:0]  exp_code;
        logic [15:0] cd;
        bus.x_flat = 48'({$urandom(), $urandom()});
        if (co_write) begin
            ca = $urandom_range(0, NB - 1);
            cd = 16'($urandom());
            bus.wr_valid = 1'b1; bus.wr_addr = 5'(ca); bus.wr_data = cd;
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.wr_valid = 1'b0;
        if (co_write) model_write(ca, cd);
        check_val("busy_run", busy, 1'b1);
        check_val("solver_en_run", bus.solver_en, 1'b1);
        check_val("wr_ready_run", bus.wr_ready, 1'b0);
        check_val("err_clr_run", err_code, 3'd0);
        check_bank("run_start");
        cycles = 0;
        while (busy === 1'b1 && cycles < 64) begin
            if (cycles == 1) begin
                bus.wr_valid = 1'b1;
                bus.wr_addr  = 5'($urandom_range(0, 31));
                bus.wr_data  = 16'($urandom());
            end
            if (cycles == 2) bus.start = 1'b1;
            if (cycles == lat) begin
                bus.solver_done = 1'b1; bus.x_flat = xv;
                bus.err_ovf = ovf; bus.err_dbz = dbz; bus.err_fsm = fsm;
            end
            tick();
            cycles++;
            bus.solver_done = 1'b0; bus.err_ovf = 1'b0; bus.err_dbz = 1'b0; bus.err_fsm = 1'b0;
            bus.wr_valid = 1'b0; bus.start = 1'b0;
            bus.x_flat = 48'({$urandom(), $urandom()});
        end
        if (lat < TIMEOUT) begin
            exp_cycles = lat + 1;
            exp_code = ovf ? 3'd1 : dbz ? 3'd2 : fsm ? 3'd3 : 3'd0;
            if (exp_code == 3'd0) x_m = xv;
        end else begin
            exp_cycles = TIMEOUT;
            exp_code = 3'd4;
        end
        err_m = exp_code;
        done_m = (exp_code == 3'd0);
        check_val("run_cycles", cycles, exp_cycles);
        check_val("err_code", err_code, err_m);
        check_val("done", done, done_m);
        check_val("solver_en_end", bus.solver_en, 1'b0);
        check_val("wr_ready_end", bus.wr_ready, 1'b1);
        // A stray completion outside RUN must not disturb status or results.
        bus.solver_done = 1'b1; bus.err_ovf = 1'b1;
        tick();
        bus.solver_done = 1'b0; bus.err_ovf = 1'b0;
        check_val("stray_err_code", err_code, err_m);
        check_val("stray_done", done, done_m);
        check_bank("after_run");
        for (int i = 0; i < N; i++) read_check(i);
    endtask

    logic [15:0] a_tp [NA] = '{16'h0010, 16'h0010, 16'h0010,
                              16'h0060, 16'hFFC0, 16'h0050,
                              16'h0050, 16'h0020, 16'h0020};
    logic [15:0] c_tp [N]  = '{16'h0020, 16'h01F0, 16'h00D0};

    initial begin
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 1'b0;
        bus.x_flat = '0; bus.solver_done = 1'b0;
        bus.err_ovf = 1'b0; bus.err_dbz = 1'b0; bus.err_fsm = 1'b0;
        rd_sel = '0; scroll_en = 1'b0;
        model_reset();
        tick(); tick();
        rst = 1'b0;

        check_bank("reset");
        check_val("reset_rd_data", rd_data, 16'h0000);
        check_val("reset_wr_ready", bus.wr_ready, 1'b1);
        check_val("reset_err_code", err_code, 3'd0);
        check_val("reset_busy", busy, 1'b0);
        check_val("reset_done", done, 1'b0);
        check_val("reset_solver_en", bus.solver_en, 1'b0);

        for (int i = 0; i < NA; i++) do_write(i, a_tp[i]);
        for (int i = 0; i < N; i++)  do_write(NA + i, c_tp[i]);
        run_solve(5, 1'b0, 1'b0, 1'b0, {16'h0010, 16'hFFE0, 16'h0030}, 1'b0);
        for (int s = N; s < N + NB + 2; s++) read_check(s);

        run_solve(100, 1'b0, 1'b0, 1'b0, 48'h1234_5678_9ABC, 1'b0);
        run_solve(3, 1'b1, 1'b1, 1'b0, 48'hDEAD_BEEF_CAFE, 1'b0);
        run_solve(TIMEOUT - 1, 1'b0, 1'b0, 1'b1, 48'h0102_0304_0506, 1'b0);

        do_write(12, 16'hABCD);
        run_solve(2, 1'b0, 1'b0, 1'b0, 48'h0003_0002_0001, 1'b1);

        scroll_en = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            check_val($sformatf("scroll_k%0d", k), rd_data, x_m[(((k - 1) / SCROLL_DIV) % N)*16 +: 16]);
        end
        scroll_en = 1'b0;
        tick();

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        check_val("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_val("rst_run_busy", busy, 1'b0);
        check_val("rst_run_solver_en", bus.solver_en, 1'b0);
        check_val("rst_run_wr_ready", bus.wr_ready, 1'b1);
        check_val("rst_run_rd_data", rd_data, 16'h0000);
        check_bank("rst_run");

        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++)
                do_write($urandom_range(0, 15), 16'($urandom()));
            read_check($urandom_range(0, 17));
            read_check($urandom_range(0, 17));
            run_solve($urandom_range(0, 20),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) == 0),
                      48'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/lin_sys_ctrl.md
# lin_sys_ctrl

Parametrised controller for the fixed-point linear-system solver. Holds an N×N coefficient matrix and N-entry constant vector in a writable register bank, launches the solver with a start/done handshake, runs a timeout watchdog, latches results and error status, and drives a selectable or auto-scrolling read-out word to the signed decimal 7-segment decoder. Replaces hard-wired coefficients and a fixed display mux with a runtime-loadable, N-generic control path.

## Interface
- DW, 16, data width; two's-complement fixed point with FRAC fractional bits
- FRAC, 4, fractional bits; 1.0 = 1<<FRAC
- N, 3, system order (2..4)
- TIMEOUT, 4096, max solver cycles before watchdog error (≥2)
- SCROLL_DIV, 50_000_000, cycles per auto-scroll step (≥1)
- SENTINEL, 16'h0FF0, read-out value for unmapped selects
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  coefficient write request
- wr_ready  out  1  bank writable (state IDLE, DONE or ERR)
- wr_addr  in  5  0..N*N-1 → A[r][c] row-major (addr = r*N+c); N*N..N*N+N-1 → C[i]
- wr_data  in  DW  coefficient value
- start  in  1  solve request; one-cycle pulse or level
- solver_en  out  1  solver enable, high throughout RUN
- a_flat  out  N*N*DW  A bank, A[r][c] at bits [(r*N+c)*DW +: DW]
- c_flat  out  N*DW  C bank, C[i] at [i*DW +: DW]
- x_flat  in  N*DW  solver results
- solver_done, err_ovf, err_dbz, err_fsm  in  1 each  solver status
- busy  out  1  state == RUN
- done  out  1  state == DONE
- err_code  out  3  0 none, 1 ovf, 2 dbz, 3 solver FSM, 4 timeout
- addr_err  out  1  sticky: write to out-of-range address seen
- rd_sel  in  5  0..N-1 X[i]; N..N+N*N-1 A row-major; N+N*N..2N+N*N-1 C[i]
- scroll_en  in  1  auto-scroll X[0..N-1]
- rd_data  out  DW  read-out word, registered

## Operation
- States: IDLE, RUN, DONE, ERR. Reset → IDLE.
- IDLE/DONE/ERR: wr_ready=1; write on wr_valid&wr_ready. Address ≥ N*N+N: no bank change, addr_err set (cleared only by rst).
- start in IDLE/DONE/ERR → RUN; clears err_code, zeroes watchdog. start in RUN ignored.
- Write and start in same cycle: write commits at that edge; solver sees the new value from the first RUN cycle.
- RUN: wr_ready=0, writes dropped; watchdog increments each cycle.
- solver_done in RUN: any err_* set → ERR with err_code by priority ovf > dbz > fsm; else latch x_flat into result registers → DONE.
- Watchdog reaches TIMEOUT-1 without solver_done → ERR, err_code=4, results unchanged.
- solver_done outside RUN ignored.
- Read-out: scroll_en=0 → rd_data = bank/result word per rd_sel, SENTINEL for unmapped. scroll_en=1 → scroll index steps 0..N-1, wrapping, every SCROLL_DIV cycles; index resets to 0 on scroll_en rising edge.
- Reset values: A = identity (diagonal 1<<FRAC, else 0), C = 0, results = 0, err_code=0, addr_err=0, solver_en=0, busy=0, done=0, wr_ready=1, rd_data=0, scroll index 0.
- No arithmetic beyond counters; result words passed through unmodified.

## Timing
- Write: data visible on a_flat/c_flat the cycle after the accepting edge.
- start sampled at edge k → busy/solver_en high from k+1.
- solver_done at edge m → done or err_code valid from m+1; solver_en low from m+1.
- rd_data: one cycle after rd_sel or scroll index change.
- rst mid-RUN: next cycle IDLE, solver_en=0, bank back to reset values.

## Structure
- Shared package: state enum, err_code constants, DW/FRAC defaults, FP_ONE = 1<<FRAC.
- One sub-module: lin_sys_readout_mux (rd_sel/scroll decode, scroll counter, output register).

## Test plan
- Reset → a_flat diagonal 0x0010, c_flat 0, rd_data 0, wr_ready 1, err_code 0.
- Write A = [1,1,1;6,-4,5;5,2,2] (0x0010,…,0xFFC0,…), C = [2,31,13]; start; model solver returns 0x0030,0xFFE0,0x0010 with done → done=1; rd_sel 0/1/2 → 0x0030/0xFFE0/0x0010.
- Solver never asserts done, TIMEOUT=16 → ERR, err_code=4 after 16 RUN cycles.
- done with err_ovf and err_dbz both high → err_code=1; x results unchanged.
- wr_addr=12 with N=3 → bank unchanged, addr_err=1; write during RUN dropped (wr_ready=0).
- scroll_en=1, SCROLL_DIV=4 → rd_data cycles X0,X1,X2,X0 every 4 cycles; rst mid-RUN → IDLE, solver_en=0 next cycle.
